oven_cook_ctrl: RTL and testbench

//   Cooking-cycle controller of the oven, directly downstream of the button conditioners.

---
 rtl/oven_cook_ctrl.sv | 167 ++++++++++++++++
 tb/tb_oven_cook_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/oven_cook_ctrl.sv
// oven_cook_ctrl: cooking-cycle controller for the oven.
// Takes the 1-cycle short/long press pulses from the button conditioners.
// Sets the cooking time and counts it down once per second.
// Drives the heater while cooking, and gives a timed beep when the cycle completes.
//
// Optional feature macro: OVEN_DOOR_INTERLOCK_EN (door interlock).
// When it is undefined, door_open is ignored.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start_short  start/pause/acknowledge pulse
//   cancel_long  cancel pulse (highest priority)
//   add_short    +ADD_STEP seconds pulse
//   door_open    synchronised door level (used only with the interlock)
//   heater       1 while cooking
//   beep         completion tone enable
//   done         1 while in DONE
//   remaining    seconds left
//   state_o      IDLE=0 READY=1 COOK=2 PAUSE=3 DONE=4
module oven_cook_ctrl #(
    parameter int unsigned SECONDS   = 50_000_000,
    parameter int unsigned ADD_STEP  = 30,
    parameter int unsigned MAX_SECS  = 255,
    parameter int unsigned DONE_SECS = 3,
    parameter int unsigned TIME_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_short,
    input  logic              cancel_long,
    input  logic              add_short,
    input  logic              door_open,
    output logic              heater,
    output logic              beep,
    output logic              done,
    output logic [TIME_W-1:0] remaining,
    output logic [2:0]        state_o
);

    localparam int unsigned PRE_W    = (SECONDS > 1) ? $clog2(SECONDS) : 1;
    localparam int unsigned BEEP_CYC = DONE_SECS * SECONDS;
    localparam int unsigned BEEP_W   = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [PRE_W-1:0]    presc, presc_n;
    logic [TIME_W-1:0]   rem_n, rem_dec;
    logic [BEEP_W-1:0]   bcnt, bcnt_n;
    logic                beep_n;
    logic                door;
    logic                tick;

`ifdef OVEN_DOOR_INTERLOCK_EN
    assign door = door_open;
`else
    logic door_unused;
    assign door        = 1'b0;
    assign door_unused = door_open;
`endif

    // Saturating add of one ADD_STEP; the extra bit catches overflow before clamping.
    function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] v);
        logic [TIME_W:0] sum;
        sum = {1'b0, v} + (TIME_W+1)'(ADD_STEP);
        if (sum > (TIME_W+1)'(MAX_SECS)) return TIME_W'(MAX_SECS);
        return sum[TIME_W-1:0];
    endfunction

    // One-second tick, and the remaining time after that tick (floored at 0).
    assign tick    = (state == COOK) && (presc == PRE_W'(SECONDS - 1));
    assign rem_dec = (tick && remaining != '0) ? remaining - TIME_W'(1) : remaining;

    // Next state and datapath.
    always_comb begin
        state_n = state;
        presc_n = presc;
        rem_n   = remaining;
        bcnt_n  = bcnt;
        beep_n  = beep;
        if (cancel_long) begin
            state_n = IDLE;
            presc_n = '0;
            rem_n   = '0;
            bcnt_n  = '0;
            beep_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_short) begin
                        rem_n   = TIME_W'(ADD_STEP);
                        presc_n = '0;
                        state_n = door ? READY : COOK;
                    end else if (add_short) begin
                        rem_n   = sat_add(remaining);
                        state_n = READY;
                    end
                end
                READY, PAUSE: begin
                    if (start_short) begin
                        if (!door) state_n = COOK;
                    end else if (add_short) begin
                        rem_n = sat_add(remaining);
                    end
                end
                COOK: begin
                    presc_n = tick ? '0 : presc + PRE_W'(1);
                    rem_n   = rem_dec;
                    // An add that lands on the final tick keeps us cooking.
                    if (!door && !start_short && add_short) begin
                        rem_n = sat_add(rem_dec);
                    end else if (tick && remaining == TIME_W'(1)) begin
                        state_n = DONE;
                        rem_n   = '0;
                        presc_n = '0;
                        bcnt_n  = BEEP_W'(BEEP_CYC - 1);
                        beep_n  = 1'b1;
                    end else if (door || start_short) begin
                        state_n = PAUSE;
                    end
                end
                DONE: begin
                    if (door || start_short) begin
                        state_n = IDLE;
                        bcnt_n  = '0;
                        beep_n  = 1'b0;
                    end else if (bcnt != '0) begin
                        bcnt_n = bcnt - BEEP_W'(1);
                    end else begin
                        beep_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            remaining <= '0;
            bcnt      <= '0;
            beep      <= 1'b0;
            heater    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            remaining <= rem_n;
            bcnt      <= bcnt_n;
            beep      <= beep_n;
            heater    <= (state_n == COOK);
            done      <= (state_n == DONE);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_oven_cook_ctrl.sv
// Testbench for oven_cook_ctrl: directed scenarios, then random pulses.
// All outputs are checked every cycle against a behavioural model.
module tb_oven_cook_ctrl;

    localparam int unsigned SECONDS   = 4;
    localparam int unsigned ADD_STEP  = 3;
    localparam int unsigned MAX_SECS  = 10;
    localparam int unsigned DONE_SECS = 2;
    localparam int unsigned TIME_W    = 8;
`ifdef OVEN_DOOR_INTERLOCK_EN
    localparam bit INTERLOCK = 1'b1;
`else
    localparam bit INTERLOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_short = 1'b0, cancel_long = 1'b0, add_short = 1'b0, door_open = 1'b0;
    logic heater, beep, done;
    logic [TIME_W-1:0] remaining;
    logic [2:0] state_o;

    oven_cook_ctrl #(
        .SECONDS(SECONDS), .ADD_STEP(ADD_STEP), .MAX_SECS(MAX_SECS),
        .DONE_SECS(DONE_SECS), .TIME_W(TIME_W)
    ) dut (
        .clk(clk), .rst(rst), .start_short(start_short), .cancel_long(cancel_long),
        .add_short(add_short), .door_open(door_open), .heater(heater), .beep(beep),
        .done(done), .remaining(remaining), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0..4, seconds left, cycles into current second, beep cycles left.
    int m_mode, m_secs, m_phase, m_beep_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int add_sat(input int v);
        return (v + ADD_STEP > MAX_SECS) ? MAX_SECS : v + ADD_STEP;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_secs = 0; m_phase = 0; m_beep_left = 0;
    endtask

    task automatic model_step(input bit st, input bit ca, input bit ad, input bit dr);
        bit door, second_ends;
        int left;
        door = INTERLOCK && dr;
        if (ca) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (st) begin
                   m_secs = ADD_STEP; m_phase = 0; m_mode = door ? 1 : 2;
               end else if (ad) begin
                   m_secs = add_sat(m_secs); m_mode = 1;
               end
            1, 3: if (st) begin
                      if (!door) m_mode = 2;
                  end else if (ad) begin
                      m_secs = add_sat(m_secs);
                  end
            2: begin
                second_ends = (m_phase == SECONDS - 1);
                m_phase     = (m_phase + 1) % SECONDS;
                left        = (second_ends && m_secs > 0) ? m_secs - 1 : m_secs;
                if (!door && !st && ad) m_secs = add_sat(left);
                else if (second_ends && m_secs == 1) begin
                    m_mode = 4; m_secs = 0; m_phase = 0; m_beep_left = DONE_SECS * SECONDS;
                end else begin
                    m_secs = left;
                    if (door || st) m_mode = 3;
                end
            end
            4: if (door || st) begin
                   m_mode = 0; m_beep_left = 0;
               end else if (m_beep_left > 0) begin
                   m_beep_left--;
               end
            default: m_mode = 0;
        endcase
    endtask

    task automatic compare_all();
        check("state",     32'(state_o),   32'(m_mode));
        check("remaining", 32'(remaining), 32'(m_secs));
        check("flags",     32'({heater, beep, done}),
              32'({m_mode == 2, m_beep_left > 0, m_mode == 4}));
    endtask

    // One clock with the given pulses; outputs compared 1 time unit after the edge.
    task automatic step(input bit st, input bit ca, input bit ad, input bit dr);
        start_short = st; cancel_long = ca; add_short = ad; door_open = dr;
        @(posedge clk);
        model_step(st, ca, ad, dr);
        #1;
        start_short = 1'b0; cancel_long = 1'b0; add_short = 1'b0;
        compare_all();
    endtask

    initial begin
        int k, nb;
        int exp_add[4];

        // 1: reset
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_flags", 32'({heater, beep, done}), 32'd0);

        // 2: full cook cycle and beep length
        step(0, 0, 1, 0);
        check("t2_ready_rem", 32'(remaining), 32'd3);
        step(1, 0, 0, 0);
        check("t2_heater_on", 32'(heater), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("t2_rem_after_1s", 32'(remaining), 32'd2);
        k = 0;
        while (!done && k < 30) begin step(0, 0, 0, 0); k++; end
        check("t2_done_reached", 32'(done), 32'd1);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (beep) nb++;
            step(0, 0, 0, 0);
        end
        check("t2_beep_cycles", 32'(nb), 32'(DONE_SECS * SECONDS));
        step(1, 0, 0, 0);
        check("t2_ack_idle", 32'(state_o), 32'd0);

        // 3: pause keeps the partial second
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("t3_pause_state", 32'(state_o), 32'd3);
        check("t3_pause_rem", 32'(remaining), 32'd2);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t3_resume_rem", 32'(remaining), 32'd1);
        step(0, 1, 0, 0);

        // 4: saturation from IDLE
        exp_add = '{3, 6, 9, 10};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0);
            check("t4_add_rem", 32'(remaining), 32'(exp_add[i]));
        end
        check("t4_ready", 32'(state_o), 32'd1);
        step(0, 1, 0, 0);

        // 5: cancel beats start
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        check("t5_cancel_state", 32'(state_o), 32'd0);
        check("t5_cancel_rem", 32'(remaining), 32'd0);
        check("t5_cancel_heater", 32'(heater), 32'd0);

        // 6: door opened mid-cook
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        check("t6_door_heater", 32'(heater), INTERLOCK ? 32'd0 : 32'd1);
        step(1, 0, 0, 1);
        check("t6_door_start", 32'(state_o), INTERLOCK ? 32'd3 : 32'd3);
        check("t6_door_heater2", 32'(heater), 32'd0);
        step(0, 1, 0, 0);

        // Random pulses with a slowly changing door level
        for (int i = 0; i < 3000; i++) begin
            bit dr;
            dr = door_open;
            if ($urandom_range(0, 15) == 0) dr = ~dr;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 5) == 0, dr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
